lsu_arbiter: RTL

- Two-requester arbiter sharing the single LSU VALID/READY port between the CPU core (m0) and the debug/program-loader master (m1).
- Sits between both masters and the LSU. Forwards the granted master's address, store data, strobe and write-enable, then routes load data and READY back to that master only.
- Round-robin fairness. The grant is locked for the whole transaction.
- A watchdog ends stalled transactions with an error response.

---
 rtl/singlecycle_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 20 ++
 rtl/lsu_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/singlecycle_pkg.sv
// Shared types and constants for the LSU request path.
package singlecycle_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        wren;
    } lsu_req_t;

    localparam int LSU_TIMEOUT_DEFAULT = 1024;

    // Watchdog counter width; a disabled watchdog still keeps a 1-bit counter.
    function automatic int tmo_width(int cyc);
        return (cyc > 0) ? $clog2(cyc + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: ptr names the favoured requester on a tie.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt_onehot,
    output logic       gnt_idx
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        gnt_idx = 1'b0;
        case (req)
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ptr;
            default: gnt_idx = 1'b0;
        endcase
        gnt_onehot = (|req) ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
    end

endmodule

// File: rtl/lsu_arbiter.sv
// Shares one LSU VALID/READY port between the core (m0) and the debug loader (m1),
// with round-robin fairness, a grant locked per transaction, and a stall watchdog.
module lsu_arbiter
    import singlecycle_pkg::*;
#(
    parameter int TIMEOUT_CYC = LSU_TIMEOUT_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_m0_valid,
    output logic        o_m0_ready,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [3:0]  i_m0_strb,
    input  logic        i_m0_wren,
    output logic [31:0] o_m0_rdata,
    output logic        o_m0_err,

    input  logic        i_m1_valid,
    output logic        o_m1_ready,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic [3:0]  i_m1_strb,
    input  logic        i_m1_wren,
    output logic [31:0] o_m1_rdata,
    output logic        o_m1_err,

    output logic        o_VALID,
    input  logic        i_READY,
    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_st_data,
    output logic [3:0]  o_st_strb,
    output logic        o_lsu_wren,
    input  logic [31:0] i_ld_data
);

    localparam int               TMO_W    = tmo_width(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = '1;
    localparam logic [TMO_W-1:0] CNT_ONE  = TMO_W'(1);

    arb_state_e       state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;

    lsu_req_t         m_req [2];
    lsu_req_t         bus;
    logic [1:0]       arb_onehot;
    logic             arb_idx;
    logic             sel_valid;
    logic             sel_idx;
    logic             timeout;
    logic             fwd;
    logic             complete;
    logic             resp;
    logic [31:0]      rdata;

    assign m_req[0] = '{addr: i_m0_addr, wdata: i_m0_wdata, strb: i_m0_strb, wren: i_m0_wren};
    assign m_req[1] = '{addr: i_m1_addr, wdata: i_m1_wdata, strb: i_m1_strb, wren: i_m1_wren};

    rr_arb2 u_rr_arb2 (
        .req        ({i_m1_valid, i_m0_valid}),
        .ptr        (rr_ptr_q),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx)
    );

    // Once BUSY the grant is locked: the holder stays selected even if it misbehaves.
    assign sel_valid = (state_q == ARB_BUSY) || (|arb_onehot);
    assign sel_idx   = (state_q == ARB_BUSY) ? gnt_q : arb_idx;
    assign timeout   = (TIMEOUT_CYC != 0) && (state_q == ARB_BUSY) && !i_READY
                       && (cnt_q == TMO_LAST);
    assign fwd       = i_rst_n && sel_valid && !timeout;
    assign complete  = fwd && i_READY;
    assign resp      = i_rst_n && (complete || timeout);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ARB_IDLE;
            gnt_q    <= 1'b0;
            rr_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, independent of order.
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (complete) begin
                    rr_ptr_d = ~sel_idx;
                end else if (fwd) begin
                    state_d = ARB_BUSY;
                    gnt_d   = sel_idx;
                    cnt_d   = CNT_ONE;
                end
            end
            ARB_BUSY: begin
                if (complete || timeout) begin
                    state_d  = ARB_IDLE;
                    cnt_d    = '0;
                    rr_ptr_d = ~gnt_q;
                end else if (cnt_q != TMO_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        bus        = fwd ? m_req[sel_idx] : '0;
        o_VALID    = fwd;
        o_lsu_addr = bus.addr;
        o_st_data  = bus.wdata;
        o_st_strb  = bus.strb;
        o_lsu_wren = bus.wren;

        // A timed-out transaction returns zero data alongside the error flag.
        rdata      = complete ? i_ld_data : '0;
        o_m0_ready = 1'b0;
        o_m0_rdata = '0;
        o_m0_err   = 1'b0;
        o_m1_ready = 1'b0;
        o_m1_rdata = '0;
        o_m1_err   = 1'b0;
        if (resp && !sel_idx) begin
            o_m0_ready = 1'b1;
            o_m0_rdata = rdata;
            o_m0_err   = timeout;
        end
        if (resp && sel_idx) begin
            o_m1_ready = 1'b1;
            o_m1_rdata = rdata;
            o_m1_err   = timeout;
        end
    end

endmodule
